// File: rtl/pipelined_adder.sv
// pipelined_adder: N-bit add/subtract split into STAGES carry-chained slices, one slice per clock,
// with valid/ready flow control and a signed-overflow flag.
module pipelined_adder #(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   sum,
  output logic         ovf
);
  localparam int W = N / STAGES;
  logic         w_adv;
  logic [N-1:0] w_a [STAGES+1];
  logic [N-1:0] w_b [STAGES+1];
  logic [N-1:0] w_s [STAGES+1];
  logic         w_c [STAGES+1];
  logic         w_v [STAGES+1];
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;
  assign w_v[0]   = in_valid;
  assign w_a[0]   = a;
  assign w_b[0]   = b ^ {N{sub}};
  assign w_s[0]   = '0;
  assign w_c[0]   = sub;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [N-1:0] r_a, r_b, r_s;
    logic         r_c, r_v;
    logic [W:0]   w_slice;
    assign w_slice = {1'b0, w_a[k][k*W +: W]} + {1'b0, w_b[k][k*W +: W]} + {{W{1'b0}}, w_c[k]};
    // Data only loads with a valid item so the final stage keeps its last result across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_a <= '0;
        r_b <= '0;
        r_s <= '0;
        r_c <= 1'b0;
      end else if (w_adv) begin
        r_v <= w_v[k];
        if (w_v[k]) begin
          r_a              <= w_a[k];
          r_b              <= w_b[k];
          r_c              <= w_slice[W];
          r_s              <= w_s[k];
          r_s[k*W +: W]    <= w_slice[W-1:0];
        end
      end
    end
    assign w_v[k+1] = r_v;
    assign w_a[k+1] = r_a;
    assign w_b[k+1] = r_b;
    assign w_s[k+1] = r_s;
    assign w_c[k+1] = r_c;
  end
  assign out_valid = w_v[STAGES];
  assign sum       = {w_c[STAGES], w_s[STAGES]};
  assign ovf       = (w_a[STAGES][N-1] == w_b[STAGES][N-1]) && (w_s[STAGES][N-1] != w_a[STAGES][N-1]);
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: scoreboard bench for pipelined_adder (N=8/STAGES=2 directed and backpressure,
// N=16 with STAGES 1, 4, 16 random sweep) against an arithmetic reference model.
module tb_pipelined_adder;
  typedef struct {
    longint s;
    bit     o;
    int     c;
    bit     lat;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc  = 0;
  int nchk = 0;
  int nerr = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operands, signed range test for overflow.
  function automatic void model(input int n, input longint x, input longint y, input bit s,
                                output longint r, output bit o);
    longint m = longint'(1) << n;
    longint h = longint'(1) << (n - 1);
    longint sx = (x >= h) ? x - m : x;
    longint sy = (y >= h) ? y - m : y;
    longint t = s ? sx - sy : sx + sy;
    r = s ? (((x - y) & (m - 1)) + ((x >= y) ? m : 0)) : x + y;
    o = (t < -h) || (t >= h);
  endfunction

  // ---------------- N=8, STAGES=2 ----------------
  logic       rst8_n, v8, ir8, sub8, ov8, ordy8, o8;
  logic [7:0] a8, b8;
  logic [8:0] s8;
  bit         bp8 = 0, lat8 = 1;
  ent_t       q8[$];

  pipelined_adder #(.N(8), .STAGES(2)) u8 (
    .clk(clk), .rst_n(rst8_n), .in_valid(v8), .in_ready(ir8), .a(a8), .b(b8), .sub(sub8),
    .out_valid(ov8), .out_ready(ordy8), .sum(s8), .ovf(o8)
  );

  always @(negedge clk) begin
    ent_t e;
    if (rst8_n && v8 && ir8) begin
      model(8, longint'(a8), longint'(b8), sub8, e.s, e.o);
      e.c   = cyc;
      e.lat = lat8;
      q8.push_back(e);
    end
  end

  always @(negedge clk) begin
    ent_t e;
    if (!rst8_n) q8.delete();
    else if (ov8 && ordy8) begin
      if (q8.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL out8_unexpected: got sum %0h, expected no result", s8);
      end else begin
        e = q8.pop_front();
        chk("sum8", longint'(s8), e.s);
        chk("ovf8", longint'(o8), longint'(e.o));
        if (e.lat) chk("latency8", longint'(cyc - e.c), 2);
      end
    end
  end

  bit         pst8 = 0;
  logic [8:0] ps8;
  logic       po8;
  always @(negedge clk) begin
    if (rst8_n && pst8) begin
      chk("hold_valid8", longint'(ov8), 1);
      chk("hold_sum8", longint'(s8), longint'(ps8));
      chk("hold_ovf8", longint'(o8), longint'(po8));
    end
    if (rst8_n && ov8 && !ordy8) chk("stall_in_ready8", longint'(ir8), 0);
    pst8 = rst8_n && ov8 && !ordy8;
    ps8  = s8;
    po8  = o8;
  end

  always begin
    @(posedge clk);
    #1;
    if (bp8) ordy8 = 1'($urandom_range(0, 1));
  end

  task automatic send8(input logic [7:0] x, input logic [7:0] y, input logic s);
    int n = 0;
    a8 = x; b8 = y; sub8 = s; v8 = 1'b1;
    @(negedge clk);
    while (!ir8 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!ir8) begin
      nchk++;
      nerr++;
      $display("FAIL send8_timeout: in_ready stayed 0, required 1");
    end
    @(posedge clk);
    #1 v8 = 1'b0;
  endtask

  task automatic drain8();
    int n = 0;
    while (q8.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain8_pending", longint'(q8.size()), 0);
  endtask

  // ---------------- N=16, STAGES in {1,4,16} ----------------
  logic        rst16_n, v16, sub16;
  logic [15:0] a16, b16;
  int          pend[3] = '{0, 0, 0};

  for (genvar g = 0; g < 3; g++) begin : g16
    localparam int S = (g == 0) ? 1 : (g == 1) ? 4 : 16;
    logic        ir, ov, o;
    logic [16:0] s;
    ent_t        q[$];
    pipelined_adder #(.N(16), .STAGES(S)) u (
      .clk(clk), .rst_n(rst16_n), .in_valid(v16), .in_ready(ir), .a(a16), .b(b16), .sub(sub16),
      .out_valid(ov), .out_ready(1'b1), .sum(s), .ovf(o)
    );
    always @(negedge clk) begin
      ent_t e;
      if (rst16_n && v16 && ir) begin
        model(16, longint'(a16), longint'(b16), sub16, e.s, e.o);
        e.c   = cyc;
        e.lat = 1;
        q.push_back(e);
        pend[g]++;
      end
    end
    always @(negedge clk) begin
      ent_t e;
      if (!rst16_n) begin
        q.delete();
        pend[g] = 0;
      end else if (ov) begin
        if (q.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL out16_s%0d_unexpected: got sum %0h, expected no result", S, s);
        end else begin
          e = q.pop_front();
          pend[g]--;
          chk($sformatf("sum16_s%0d", S), longint'(s), e.s);
          chk($sformatf("ovf16_s%0d", S), longint'(o), longint'(e.o));
          chk($sformatf("latency16_s%0d", S), longint'(cyc - e.c), S);
        end
      end
    end
  end

  initial begin
    int sent, n;
    rst8_n = 0; rst16_n = 0; v8 = 0; v16 = 0; ordy8 = 1;
    a8 = 0; b8 = 0; sub8 = 0; a16 = 0; b16 = 0; sub16 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid8", longint'(ov8), 0);
    chk("reset_sum8", longint'(s8), 0);
    chk("reset_ovf8", longint'(o8), 0);
    chk("reset_in_ready8", longint'(ir8), 1);
    @(posedge clk);
    #1 rst8_n = 1; rst16_n = 1;

    // Directed vectors with out_ready held high; latency is checked.
    send8(8'hFF, 8'h01, 1'b0);
    send8(8'h05, 8'h07, 1'b1);
    send8(8'h80, 8'h01, 1'b1);
    send8(8'h7F, 8'h01, 1'b0);
    send8(8'h00, 8'h00, 1'b1);
    send8(8'h80, 8'h80, 1'b0);
    drain8();

    // Reset with two items in flight; neither may ever emerge.
    send8(8'h03, 8'h04, 1'b0);
    send8(8'h10, 8'h20, 1'b0);
    rst8_n = 0;
    #1;
    chk("midrst_out_valid8", longint'(ov8), 0);
    chk("midrst_sum8", longint'(s8), 0);
    chk("midrst_in_ready8", longint'(ir8), 1);
    repeat (2) @(posedge clk);
    #1 rst8_n = 1;
    chk("after_rst_in_ready8", longint'(ir8), 1);
    send8(8'h11, 8'h22, 1'b0);
    drain8();

    // Backpressure stream 0..9, then random traffic under random out_ready.
    lat8 = 0;
    bp8  = 1;
    for (int k = 0; k < 10; k++) send8(8'h00, 8'(k), 1'b0);
    for (int k = 0; k < 200; k++) begin
      send8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    bp8 = 0;
    @(posedge clk);
    #1 ordy8 = 1;
    drain8();

    // N=16 sweep with random input bubbles and no stalls.
    sent = 0;
    while (sent < 1000) begin
      v16   = ($urandom_range(0, 3) != 0);
      a16   = 16'($urandom);
      b16   = 16'($urandom);
      sub16 = 1'($urandom_range(0, 1));
      if (v16) sent++;
      @(posedge clk);
      #1;
    end
    v16 = 0;
    n = 0;
    while ((pend[0] | pend[1] | pend[2]) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain16_s1", longint'(pend[0]), 0);
    chk("drain16_s4", longint'(pend[1]), 0);
    chk("drain16_s16", longint'(pend[2]), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
